// File: rtl/keccak_perm_arbiter.sv
// keccak_perm_arbiter
// Shares one Keccak-f[1600] permutation core between two sponge requesters:
// requester 0 (SHAKE256 absorb/squeeze) and requester 1 (SHAKE128 matrix
// expansion). The arbiter grants round-robin, latches the winner's state,
// launches the core with a one-cycle perm_rtr and returns the permuted
// state with a one-cycle done pulse. A watchdog aborts the service if the
// core never answers, and the error flag stays set until reset.
module keccak_perm_arbiter #(
  parameter int STATE_W = 1600,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic [STATE_W-1:0] state0_in,
  input  logic               req1,
  input  logic [STATE_W-1:0] state1_in,
  output logic [STATE_W-1:0] state_out,
  output logic               done0,
  output logic               done1,
  output logic               busy,
  output logic               perm_rtr,
  output logic [STATE_W-1:0] perm_state_out,
  input  logic [STATE_W-1:0] perm_state_in,
  input  logic               perm_rts,
  output logic               error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Last count value that still allows a core answer; one more WAIT cycle
  // without perm_rts means the core is considered dead.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       fsm_state;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] wdog_cnt;

  logic             arb_any;
  logic             arb_pick;
  logic             take_grant;
  logic             take_result;
  logic             wdog_expired;

  // Round-robin pick: a lone requester always wins, contention goes to the
  // requester that was not served last.
  always_comb begin
    arb_any  = req0 | req1;
    arb_pick = 1'b0;
    if (req0 && req1) begin
      arb_pick = ~last_grant;
    end else if (req1) begin
      arb_pick = 1'b1;
    end
  end

  // Qualified events shared by the control and the state-capture registers.
  always_comb begin
    take_grant   = (fsm_state == ST_IDLE) && arb_any;
    take_result  = (fsm_state == ST_WAIT) && perm_rts;
    wdog_expired = (fsm_state == ST_WAIT) && !perm_rts && (wdog_cnt == WDOG_LAST);
  end

  // Service sequencer: IDLE -> LOAD -> WAIT -> DONE, with registered strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm_state  <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wdog_cnt   <= '0;
      busy       <= 1'b0;
      perm_rtr   <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      error      <= 1'b0;
    end else begin
      perm_rtr <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      case (fsm_state)
        ST_IDLE: begin
          if (take_grant) begin
            grant      <= arb_pick;
            last_grant <= arb_pick;
            perm_rtr   <= 1'b1;
            busy       <= 1'b1;
            fsm_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog_cnt  <= '0;
          fsm_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (take_result) begin
            done0     <= ~grant;
            done1     <= grant;
            fsm_state <= ST_DONE;
          end else if (wdog_expired) begin
            error     <= 1'b1;
            busy      <= 1'b0;
            fsm_state <= ST_IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          fsm_state <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          fsm_state <= ST_IDLE;
        end
      endcase
    end
  end

  // State capture: the winner's state is frozen at grant so the requester may
  // move on, and the core result is held on state_out until the next DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perm_state_out <= '0;
      state_out      <= '0;
    end else begin
      if (take_grant) begin
        perm_state_out <= arb_pick ? state1_in : state0_in;
      end
      if (take_result) begin
        state_out <= perm_state_in;
      end
    end
  end

endmodule
